// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: data width, access-width
// encodings and the load/store unit state type.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] WL_BYTE = 2'b00;
    localparam logic [1:0] WL_HALF = 2'b01;
    localparam logic [1:0] WL_WORD = 2'b10;

    typedef enum logic {
        IDLE,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane replication / byte-enable generation and
// load lane extraction with sign or zero extension.
module lsu_align
    import core_pkg::*;
(
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      wl,
    input  logic            extend_sign,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Store side: replicate the low bytes/halves across lanes, enable the addressed ones
    always_comb begin
        case (wl)
            WL_BYTE: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            WL_HALF: begin
                wdata = {2{store_data[15:0]}};
                be    = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: begin
                wdata = store_data;
                be    = 4'b1111;
            end
        endcase
    end

    // Load side: pick the addressed lane and extend it to a full word
    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (wl)
            WL_BYTE: load_data = {{24{extend_sign & byte_lane[7]}}, byte_lane};
            WL_HALF: load_data = {{16{extend_sign & half_lane[15]}}, half_lane};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage of the 5-stage core: drives the req/gnt/rvalid data bus,
// stalls the pipeline while an access is outstanding, and holds the
// MEM/WB register. Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned
// half/word accesses (adds the misalign_err output).
module mem_stage_lsu
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc4,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] pc_imm,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    input  logic [1:0]      wl,
    input  logic            extend_sign,
    input  logic            regester_w,
    input  logic            mem_to_reg,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            pc4_to_reg,
    input  logic            pc_imm_to_reg,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall,
    output logic            bus_err,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_we
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic            misalign_err
`endif
);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_we_q, wb_we_d;
    logic            bus_err_q, bus_err_d;

    logic            mem_op;
    logic            misaligned;
    logic            complete;
    logic            timeout;
    logic            req_raw;
    logic            we_raw;
    logic [XLEN-1:0] rdata_eff;
    logic [XLEN-1:0] load_data;

    assign mem_op = mem_read | mem_write;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic misalign_err_q, misalign_err_d;
    assign misaligned = mem_op &
                        (((wl == WL_HALF) & alu_out[0]) |
                         (((wl == WL_WORD) | (wl == 2'b11)) & (alu_out[1:0] != 2'b00)));
    assign misalign_err   = misalign_err_q;
    assign misalign_err_d = misaligned & (state_q == IDLE);
`else
    assign misaligned = 1'b0;
`endif

    // A timed-out load completes with zero data
    assign rdata_eff = timeout ? '0 : dmem_rdata;

    lsu_align u_align (
        .addr_lo     (alu_out[1:0]),
        .wl          (wl),
        .extend_sign (extend_sign),
        .store_data  (store_data),
        .rdata       (rdata_eff),
        .wdata       (dmem_wdata),
        .be          (dmem_be),
        .load_data   (load_data)
    );

    // Bus FSM next state: request in IDLE, wait for rvalid or timeout in RESP
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        timeout  = 1'b0;
        req_raw  = 1'b0;
        we_raw   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (misaligned) begin
                    complete = 1'b1;
                end else if (mem_op) begin
                    req_raw = 1'b1;
                    we_raw  = mem_write;
                    if (dmem_gnt) begin
                        if (mem_write) complete = 1'b1;
                        else           state_d  = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    complete = 1'b1;
                    timeout  = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces the bus request and pipeline stall low immediately
    assign dmem_req  = req_raw & ~rst;
    assign dmem_we   = we_raw & ~rst;
    assign dmem_addr = {alu_out[31:2], 2'b00};
    assign stall     = mem_op & ~complete & ~rst;

    // MEM/WB next value: capture when not stalled, otherwise insert a bubble
    always_comb begin
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        wb_we_d   = 1'b0;
        bus_err_d = timeout;
        if (!stall) begin
            wb_rd_d = rd;
            wb_we_d = regester_w & ~misaligned;
            if (pc4_to_reg)         wb_data_d = pc4;
            else if (pc_imm_to_reg) wb_data_d = pc_imm;
            else if (mem_to_reg)    wb_data_d = load_data;
            else                    wb_data_d = alu_out;
        end
    end

    // State, timeout counter and MEM/WB registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
            wb_we_q   <= 1'b0;
            bus_err_q <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            misalign_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            wb_we_q   <= wb_we_d;
            bus_err_q <= bus_err_d;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            misalign_err_q <= misalign_err_d;
`endif
        end
    end

    assign wb_data = wb_data_q;
    assign wb_rd   = wb_rd_q;
    assign wb_we   = wb_we_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: table of single-access vectors plus
// hand-written sequences for stall length, delayed grant, timeout and reset.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc4, alu_out, pc_imm, store_data;
    logic [4:0]  rd;
    logic [1:0]  wl;
    logic        extend_sign, regester_w, mem_to_reg, mem_read, mem_write;
    logic        pc4_to_reg, pc_imm_to_reg;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall, bus_err;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;

    int errors = 0;
    int checks = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .pc4(pc4), .alu_out(alu_out), .pc_imm(pc_imm),
        .store_data(store_data), .rd(rd), .wl(wl), .extend_sign(extend_sign),
        .regester_w(regester_w), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .pc4_to_reg(pc4_to_reg), .pc_imm_to_reg(pc_imm_to_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall(stall),
        .bus_err(bus_err), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_out = '0; store_data = '0; rd = '0; wl = 2'b10; extend_sign = 1'b0;
        regester_w = 1'b0; mem_to_reg = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        pc4_to_reg = 1'b0; pc_imm_to_reg = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    endtask

    // wbsel: 0 alu_out, 1 load data, 2 pc4, 3 pc_imm
    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [1:0]  wl;
        logic        sx;
        logic        rd_op;
        logic        wr_op;
        logic [1:0]  wbsel;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wb;
        logic        exp_we;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{32'h1234, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0, 32'h1234, 1'b1};
        vecs[1]  = '{32'h55, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 4'h0, 32'h1000_0004, 1'b1};
        vecs[2]  = '{32'h55, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 4'h0, 32'h2000_0000, 1'b1};
        vecs[3]  = '{32'h103, 32'hAB, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'hABABABAB, 4'b1000, 32'h103, 1'b0};
        vecs[4]  = '{32'h200, 32'h12345678, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h78787878, 4'b0001, 32'h200, 1'b0};
        vecs[5]  = '{32'h302, 32'hDEADBEEF, 2'b01, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'hBEEFBEEF, 4'b1100, 32'h302, 1'b0};
        vecs[6]  = '{32'h300, 32'hDEADBEEF, 2'b01, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'hBEEFBEEF, 4'b0011, 32'h300, 1'b0};
        vecs[7]  = '{32'h404, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h404, 1'b0};
        vecs[8]  = '{32'h408, 32'h01020304, 2'b11, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h01020304, 4'b1111, 32'h408, 1'b0};
        vecs[9]  = '{32'h500, 32'h0, 2'b10, 1'b1, 1'b1, 1'b0, 2'd1, 32'h89ABCDEF, 32'h0, 4'h0, 32'h89ABCDEF, 1'b1};
        vecs[10] = '{32'h601, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0000_8000, 32'h0, 4'h0, 32'hFFFFFF80, 1'b1};
        vecs[11] = '{32'h603, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 2'd1, 32'hF100_0000, 32'h0, 4'h0, 32'h0000_00F1, 1'b1};
        vecs[12] = '{32'h702, 32'h0, 2'b01, 1'b0, 1'b1, 1'b0, 2'd1, 32'h8001_1234, 32'h0, 4'h0, 32'h0000_8001, 1'b1};
        vecs[13] = '{32'h700, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0000_F00F, 32'h0, 4'h0, 32'hFFFF_F00F, 1'b1};
        vecs[14] = '{32'h800, 32'h11112222, 2'b10, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h11112222, 4'b1111, 32'h800, 1'b0};

        pc4 = 32'h1000_0004;
        pc_imm = 32'h2000_0000;
        idle_inputs();

        // Reset: registered outputs clear, combinational req/stall forced low
        rst = 1'b1;
        mem_read = 1'b1;
        #12;
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 32'h0);
        chk("rst_wb_we", {31'b0, wb_we}, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
        chk("rst_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Table of single accesses; loads get gnt at once and rvalid next cycle
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            alu_out = vecs[i].alu; store_data = vecs[i].sd; wl = vecs[i].wl;
            extend_sign = vecs[i].sx; mem_read = vecs[i].rd_op; mem_write = vecs[i].wr_op;
            mem_to_reg = (vecs[i].wbsel == 2'd1);
            pc4_to_reg = (vecs[i].wbsel == 2'd2);
            pc_imm_to_reg = (vecs[i].wbsel == 2'd3);
            regester_w = vecs[i].exp_we;
            rd = 5'(i + 1);
            dmem_gnt = vecs[i].rd_op | vecs[i].wr_op;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, {31'b0, vecs[i].rd_op | vecs[i].wr_op});
            chk($sformatf("v%0d_addr", i), dmem_addr, {vecs[i].alu[31:2], 2'b00});
            if (vecs[i].wr_op) begin
                chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].exp_wdata);
                chk($sformatf("v%0d_be", i), {28'b0, dmem_be}, {28'b0, vecs[i].exp_be});
                chk($sformatf("v%0d_we", i), {31'b0, dmem_we}, 32'h1);
                chk($sformatf("v%0d_stall", i), {31'b0, stall}, 32'h0);
            end else if (vecs[i].rd_op) begin
                chk($sformatf("v%0d_we", i), {31'b0, dmem_we}, 32'h0);
                chk($sformatf("v%0d_stall_gnt", i), {31'b0, stall}, 32'h1);
                @(posedge clk); #1;
                dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = vecs[i].rdata;
                @(negedge clk);
                chk($sformatf("v%0d_stall_rv", i), {31'b0, stall}, 32'h0);
                chk($sformatf("v%0d_req_rv", i), {31'b0, dmem_req}, 32'h0);
            end else begin
                chk($sformatf("v%0d_stall", i), {31'b0, stall}, 32'h0);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_wb);
            chk($sformatf("v%0d_wb_rd", i), {27'b0, wb_rd}, 32'(i + 1));
            chk($sformatf("v%0d_wb_we", i), {31'b0, wb_we}, {31'b0, vecs[i].exp_we});
            idle_inputs();
        end

        // Half signed load, gnt at cycle 0, rvalid at cycle 3: three stall cycles
        begin
            int stall_cnt = 0;
            @(posedge clk); #1;
            idle_inputs();
            alu_out = 32'h202; wl = 2'b01; extend_sign = 1'b1; mem_read = 1'b1;
            mem_to_reg = 1'b1; regester_w = 1'b1; rd = 5'd9; dmem_gnt = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (c > 0) begin
                    @(posedge clk); #1;
                    dmem_gnt = 1'b0;
                    if (c == 1) chk("h3_bubble_we", {31'b0, wb_we}, 32'h0);
                    if (c == 3) begin dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_5555; end
                end
                @(negedge clk);
                if (stall) stall_cnt++;
            end
            chk("h3_stall_cycles", 32'(stall_cnt), 32'd3);
            @(posedge clk); #1;
            chk("h3_wb_data", wb_data, 32'hFFFF_8001);
            chk("h3_wb_we", {31'b0, wb_we}, 32'h1);
            idle_inputs();
        end

        // Byte unsigned load with gnt delayed two cycles: req held, address stable
        begin
            int held = 0;
            @(posedge clk); #1;
            idle_inputs();
            alu_out = 32'h912; wl = 2'b00; mem_read = 1'b1; mem_to_reg = 1'b1;
            regester_w = 1'b1; rd = 5'd10;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                if (dmem_req && stall && dmem_addr == 32'h910) held++;
                @(posedge clk); #1;
            end
            chk("gd_req_held", 32'(held), 32'd2);
            dmem_gnt = 1'b1;
            @(negedge clk);
            chk("gd_req_gnt", {31'b0, dmem_req}, 32'h1);
            @(posedge clk); #1;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h00F0_0000;
            @(posedge clk); #1;
            chk("gd_wb_data", wb_data, 32'h0000_00F0);
            chk("gd_wb_we", {31'b0, wb_we}, 32'h1);
            idle_inputs();
        end

        // Load timeout: bus_err 16 edges after entering RESP, zero data written back
        begin
            int n = 0;
            bit seen = 0;
            @(posedge clk); #1;
            idle_inputs();
            alu_out = 32'hA00; wl = 2'b10; mem_read = 1'b1; mem_to_reg = 1'b1;
            regester_w = 1'b1; rd = 5'd11; dmem_gnt = 1'b1;
            @(posedge clk); #1;
            dmem_gnt = 1'b0;
            dmem_rdata = 32'hDEAD_BEEF;
            for (int c = 1; c <= 40 && !seen; c++) begin
                @(posedge clk); #1;
                if (bus_err) begin seen = 1; n = c; end
            end
            chk("to_seen", {31'b0, seen}, 32'h1);
            chk("to_edges", 32'(n), 32'd16);
            chk("to_wb_data", wb_data, 32'h0);
            chk("to_wb_we", {31'b0, wb_we}, 32'h1);
            idle_inputs();
            mem_read = 1'b1;
            @(negedge clk);
            chk("to_idle_req", {31'b0, dmem_req}, 32'h1);
            @(posedge clk); #1;
            chk("to_pulse_end", {31'b0, bus_err}, 32'h0);
            idle_inputs();
        end

        // Reset in RESP abandons the access; a late rvalid is ignored in IDLE
        @(posedge clk); #1;
        idle_inputs();
        alu_out = 32'hB00; mem_read = 1'b1; mem_to_reg = 1'b1; regester_w = 1'b1;
        rd = 5'd12; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rr_stall", {31'b0, stall}, 32'h0);
        chk("rr_req", {31'b0, dmem_req}, 32'h0);
        chk("rr_wb_we", {31'b0, wb_we}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        chk("rr_late_rv_stall", {31'b0, stall}, 32'h1);
        chk("rr_late_rv_req", {31'b0, dmem_req}, 32'h1);
        @(posedge clk); #1;
        chk("rr_late_rv_wb_we", {31'b0, wb_we}, 32'h0);
        idle_inputs();
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
